// File: rtl/vga_timing.sv
// Free-running VGA timing generator (800x600@60 by default) that drives the packed VGA bus
// and emits per-line and per-frame strobes. Every output comes straight from a register.
module vga_timing #(
    parameter int H_VISIBLE = 800,
    parameter int H_FRONT   = 40,
    parameter int H_SYNC    = 128,
    parameter int H_BACK    = 88,
    parameter int V_VISIBLE = 600,
    parameter int V_FRONT   = 1,
    parameter int V_SYNC    = 4,
    parameter int V_BACK    = 23,
    parameter int SYNC_POL  = 1
) (
    input  logic        pclk,
    input  logic        rst,
    // [37:27] hcount, [26] hsync, [25] hblnk, [24:14] vcount, [13] vsync, [12] vblnk, [11:0] rgb
    output logic [37:0] vga_out,
    output logic        frame_start,
    output logic        line_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    generate
        if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_totals
            $error("vga_timing: line/frame totals must fit 11-bit counters");
        end
    endgenerate

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_BLANK  = 11'(H_VISIBLE);
    localparam logic [10:0] V_BLANK  = 11'(V_VISIBLE);
    localparam logic [10:0] HS_BEGIN = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_BEGIN = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic        POL      = (SYNC_POL != 0);

    logic [10:0] hcount, vcount;
    logic [10:0] h_next, v_next;
    logic        hsync, vsync, hblnk, vblnk;
    logic        running;
    logic        hs_act, vs_act;

    // 'running' is clear for exactly one edge after reset, which holds the counts at 0,0
    // so the first released cycle presents the frame origin with both strobes.
    always_comb begin
        h_next = 11'd0;
        v_next = 11'd0;
        if (running) begin
            if (hcount == H_LAST) begin
                h_next = 11'd0;
                v_next = (vcount == V_LAST) ? 11'd0 : vcount + 11'd1;
            end else begin
                h_next = hcount + 11'd1;
                v_next = vcount;
            end
        end
    end

    always_comb begin
        hs_act = (h_next >= HS_BEGIN) && (h_next < HS_END);
        vs_act = (v_next >= VS_BEGIN) && (v_next < VS_END);
    end

    // Flags are derived from the next counts so each one lines up with its registered count.
    always_ff @(posedge pclk) begin
        if (rst) begin
            hcount      <= 11'd0;
            vcount      <= 11'd0;
            hsync       <= ~POL;
            vsync       <= ~POL;
            hblnk       <= 1'b0;
            vblnk       <= 1'b0;
            running     <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hcount      <= h_next;
            vcount      <= v_next;
            hsync       <= hs_act ^ ~POL;
            vsync       <= vs_act ^ ~POL;
            hblnk       <= (h_next >= H_BLANK);
            vblnk       <= (v_next >= V_BLANK);
            running     <= 1'b1;
            line_start  <= (h_next == 11'd0);
            frame_start <= (h_next == 11'd0) && (v_next == 11'd0);
        end
    end

    assign vga_out = {hcount, hsync, hblnk, vcount, vsync, vblnk, 12'h000};

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a standard-timing instance and a short-frame, active-low-sync instance
// run side by side under random resets and are compared every cycle to an arithmetic model.
module tb_vga_timing;

    localparam int HT       = 1056;
    localparam int SV_VIS   = 6;
    localparam int SV_FRONT = 1;
    localparam int SV_SYNC  = 4;
    localparam int SV_BACK  = 3;
    localparam int SVT      = SV_VIS + SV_FRONT + SV_SYNC + SV_BACK;

    logic        clk;
    logic        rst;
    logic [37:0] std_bus, sml_bus;
    logic        std_fs, std_ls, sml_fs, sml_ls;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    vga_timing dut_std (
        .pclk(clk), .rst(rst), .vga_out(std_bus),
        .frame_start(std_fs), .line_start(std_ls)
    );

    vga_timing #(
        .V_VISIBLE(SV_VIS), .V_FRONT(SV_FRONT), .V_SYNC(SV_SYNC), .V_BACK(SV_BACK),
        .SYNC_POL(0)
    ) dut_sml (
        .pclk(clk), .rst(rst), .vga_out(sml_bus),
        .frame_start(sml_fs), .line_start(sml_ls)
    );

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // t = pixel clocks since the release edge (0 = frame origin), negative while in reset.
    function automatic logic [37:0] model_bus(input int t, input int vv, input int vf,
                                              input int vs, input int vb, input bit pol);
        int h, v, vt;
        bit h_act, v_act;
        if (t < 0) return {11'd0, ~pol, 1'b0, 11'd0, ~pol, 1'b0, 12'h000};
        vt    = vv + vf + vs + vb;
        h     = t % HT;
        v     = (t / HT) % vt;
        h_act = (h >= 840) && (h <= 967);
        v_act = (v >= vv + vf) && (v < vv + vf + vs);
        return {11'(h), pol ? h_act : !h_act, h >= 800,
                11'(v), pol ? v_act : !v_act, v >= vv, 12'h000};
    endfunction

    function automatic bit model_ls(input int t);
        return (t >= 0) && (t % HT == 0);
    endfunction

    function automatic bit model_fs(input int t, input int vt);
        return (t >= 0) && (t % (HT * vt) == 0);
    endfunction

    // ---------------- driver / scoreboard ----------------
    int t   = -1;
    int cyc = 0;
    int ls_last = 0;  bit ls_valid = 0;
    int fs_last = 0;  bit fs_valid = 0;
    int active_cnt = 0;
    int n_fp = 0;

    task automatic cycle(input bit r);
        @(negedge clk);
        check("std_bus", 64'(std_bus), 64'(model_bus(t, 600, 1, 4, 23, 1'b1)));
        check("std_line_start", 64'(std_ls), 64'(model_ls(t)));
        check("std_frame_start", 64'(std_fs), 64'(model_fs(t, 628)));
        check("sml_bus", 64'(sml_bus), 64'(model_bus(t, SV_VIS, SV_FRONT, SV_SYNC, SV_BACK, 1'b0)));
        check("sml_line_start", 64'(sml_ls), 64'(model_ls(t)));
        check("sml_frame_start", 64'(sml_fs), 64'(model_fs(t, SVT)));

        if (t < 0) begin
            ls_valid = 0;
            fs_valid = 0;
        end else begin
            if (std_ls) begin
                if (ls_valid) check("line_period", 64'(cyc - ls_last), 64'(HT));
                ls_last  = cyc;
                ls_valid = 1;
            end
            if (sml_fs) begin
                if (fs_valid) begin
                    check("frame_period", 64'(cyc - fs_last), 64'(HT * SVT));
                    check("active_pixels", 64'(active_cnt), 64'(800 * SV_VIS));
                    n_fp++;
                end
                fs_last    = cyc;
                fs_valid   = 1;
                active_cnt = 0;
            end
            if (!sml_bus[25] && !sml_bus[12]) active_cnt++;
        end

        rst = r;
        t   = r ? -1 : t + 1;
        cyc++;
    endtask

    initial begin
        int rst_left;
        rst      = 1'b1;
        rst_left = 0;
        repeat (3) cycle(1'b1);
        // two complete short frames so both wraps are observed
        repeat (2 * HT * SVT + 600) cycle(1'b0);
        // mid-frame reset held for three cycles
        repeat (3) cycle(1'b1);
        repeat (2000) cycle(1'b0);
        // random resets of 1..3 cycles
        for (int i = 0; i < 12000; i++) begin
            if (rst_left == 0 && $urandom_range(0, 2999) == 0) rst_left = $urandom_range(1, 3);
            if (rst_left > 0) begin
                rst_left--;
                cycle(1'b1);
            end else begin
                cycle(1'b0);
            end
        end
        repeat (2) cycle(1'b0);
        check("frame_periods_seen", 64'(n_fp >= 2), 64'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
